// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : motor_pkg
// Description : Shared types and constants for the stepper-motor control
//               blocks (quarter-turn controller and friends).
// Revision    : 1.0 - initial release
// ============================================================================
package motor_pkg;

    // Quarter-turn sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } qt_state_t;

    // Half-steps for one full output-shaft revolution of the geared stepper
    localparam int STEPS_PER_REV_HALF = 4096;

    // Board system clock
    localparam int DEFAULT_CLK_HZ     = 50_000_000;

endpackage : motor_pkg
`default_nettype wire

// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : key_debouncer
// Description : Synchronises an asynchronous active-low push-button, filters
//               contact bounce and emits a one-cycle pulse on each accepted
//               press.
// Revision    : 1.0 - initial release
//
// Ports
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset
//   key_n       in   raw button, active-low, asynchronous to clk
//   pressed     out  debounced level, 1 = button held
//   press_pulse out  one-cycle pulse on a released->pressed transition
// ============================================================================
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse
);

    localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("key_debouncer: DEBOUNCE_CYCLES must be at least 1");
    end

    logic [1:0]         r_sync;     // [1] is the synchronised level
    logic               r_db_n;     // debounced level, active-low
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_pulse;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_db_n  <= 1'b1;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], key_n};
            r_pulse <= 1'b0;
            if (r_sync[1] == r_db_n) begin
                // Any return to the accepted level restarts the stability window
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_w'(DEBOUNCE_CYCLES - 1)) begin
                r_db_n  <= r_sync[1];
                r_cnt   <= '0;
                r_pulse <= ~r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign pressed     = ~r_db_n;
    assign press_pulse = r_pulse;

endmodule : key_debouncer
`default_nettype wire

// File: rtl/quarter_turn_controller.sv
`default_nettype none
// ============================================================================
// Module      : quarter_turn_controller
// Description : One button press -> one 90 degree move. Debounces the key,
//               then issues exactly STEPS_PER_QUARTER step ticks at STEP_HZ
//               while holding quarter_active high, and pulses quarter_done.
// Revision    : 1.0 - initial release
//
// Ports
//   clk            in   system clock
//   rst_n          in   synchronous active-low reset
//   key_n          in   raw quarter-turn button, active-low, asynchronous
//   dir_in         in   requested direction (1 = CW), sampled at move start
//   on_switch      in   continuous-mode switch, blocks new quarter requests
//   quarter_active out  high for the whole quarter move
//   step_tick      out  one-cycle pulse per step while a move runs
//   dir_out        out  direction latched for the current move
//   step_count     out  ticks issued in the current move
//   quarter_done   out  one-cycle pulse when the move completes
// ============================================================================
module quarter_turn_controller
    import motor_pkg::*;
#(
    parameter int CLK_HZ            = DEFAULT_CLK_HZ,
    parameter int STEP_HZ           = 500,
    parameter int STEPS_PER_QUARTER = STEPS_PER_REV_HALF / 4,
    parameter int DEBOUNCE_CYCLES   = 500_000
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   key_n,
    input  logic                                   dir_in,
    input  logic                                   on_switch,
    output logic                                   quarter_active,
    output logic                                   step_tick,
    output logic                                   dir_out,
    output logic [$clog2(STEPS_PER_QUARTER+1)-1:0] step_count,
    output logic                                   quarter_done
);

    localparam int c_period     = CLK_HZ / STEP_HZ;
    localparam int c_presc_w    = (c_period > 2) ? $clog2(c_period) : 1;
    localparam int c_sc_w       = $clog2(STEPS_PER_QUARTER + 1);
    // A key held through reset is debounced as a fresh press once reset
    // lifts. Moves are only accepted after the debounced key has been seen
    // released for this long following reset, which swallows that phantom
    // press and forces a real release/re-press.
    localparam int c_arm_cycles = 2 * DEBOUNCE_CYCLES + 4;
    localparam int c_arm_w      = $clog2(c_arm_cycles + 1);

    if (c_period < 2) begin : g_bad_period
        $error("quarter_turn_controller: CLK_HZ/STEP_HZ must be at least 2");
    end
    if (STEPS_PER_QUARTER < 1) begin : g_bad_steps
        $error("quarter_turn_controller: STEPS_PER_QUARTER must be at least 1");
    end

    logic w_pressed;
    logic w_press_pulse;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debouncer (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_n       (key_n),
        .pressed     (w_pressed),
        .press_pulse (w_press_pulse)
    );

    qt_state_t            r_state;
    logic [c_presc_w-1:0] r_presc;
    logic [c_sc_w-1:0]    r_step_count;
    logic                 r_qa;
    logic                 r_tick;
    logic                 r_done;
    logic                 r_dir;
    logic                 r_armed;
    logic [c_arm_w-1:0]   r_arm_cnt;

    logic w_presc_last;
    assign w_presc_last = (r_presc == c_presc_w'(c_period - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_presc      <= '0;
            r_step_count <= '0;
            r_qa         <= 1'b0;
            r_tick       <= 1'b0;
            r_done       <= 1'b0;
            r_dir        <= 1'b0;
            r_armed      <= 1'b0;
            r_arm_cnt    <= '0;
        end else begin
            r_done <= 1'b0;

            if (!r_armed) begin
                if (w_pressed) begin
                    r_arm_cnt <= '0;
                end else if (r_arm_cnt == c_arm_w'(c_arm_cycles - 1)) begin
                    r_armed <= 1'b1;
                end else begin
                    r_arm_cnt <= r_arm_cnt + 1'b1;
                end
            end

            unique case (r_state)
                IDLE: begin
                    r_tick <= 1'b0;
                    // A press seen while on_switch is set is simply dropped
                    if (w_press_pulse && r_armed && !on_switch) begin
                        r_state      <= RUN;
                        r_qa         <= 1'b1;
                        r_dir        <= dir_in;
                        r_step_count <= '0;
                        r_presc      <= '0;
                    end
                end

                RUN: begin
                    r_presc <= w_presc_last ? '0 : r_presc + 1'b1;
                    // Registered tick lands in the cycle the prescaler is P-1
                    r_tick  <= (r_presc == c_presc_w'(c_period - 2));
                    if (r_tick) begin
                        r_step_count <= r_step_count + 1'b1;
                        if (r_step_count == c_sc_w'(STEPS_PER_QUARTER - 1)) begin
                            r_qa    <= 1'b0;
                            r_done  <= 1'b1;
                            r_tick  <= 1'b0;
                            r_presc <= '0;
                            r_state <= w_pressed ? HOLD : IDLE;
                        end
                    end
                end

                HOLD: begin
                    r_tick <= 1'b0;
                    if (!w_pressed) begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_tick  <= 1'b0;
                    r_qa    <= 1'b0;
                end
            endcase
        end
    end

    assign quarter_active = r_qa;
    assign step_tick      = r_tick;
    assign dir_out        = r_dir;
    assign step_count     = r_step_count;
    assign quarter_done   = r_done;

endmodule : quarter_turn_controller
`default_nettype wire

// File: tb/tb_quarter_turn_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_quarter_turn_controller
// Description : Self-checking bench for quarter_turn_controller. Stimulus
//               pushes the expected direction of each complete move into a
//               queue; a monitor measures every move and checks it against
//               the popped entry when quarter_done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quarter_turn_controller;

    localparam int P = 4;   // 1000 / 250
    localparam int S = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_n;
    logic       dir_in;
    logic       on_switch;
    logic       quarter_active;
    logic       step_tick;
    logic       dir_out;
    logic [3:0] step_count;
    logic       quarter_done;

    always #5 clk = ~clk;

    quarter_turn_controller #(
        .CLK_HZ            (1000),
        .STEP_HZ           (250),
        .STEPS_PER_QUARTER (S),
        .DEBOUNCE_CYCLES   (5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .key_n          (key_n),
        .dir_in         (dir_in),
        .on_switch      (on_switch),
        .quarter_active (quarter_active),
        .step_tick      (step_tick),
        .dir_out        (dir_out),
        .step_count     (step_count),
        .quarter_done   (quarter_done)
    );

    int   errors = 0;
    int   checks = 0;
    logic exp_q[$];
    int   done_seen = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit   in_move = 0;
    int   qa_len, nticks, first_off, last_tick, spacing_bad;
    logic dir0, exp_dir;
    bit   dir_bad;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_move = 0;
        end else begin
            if (step_tick && !quarter_active) check("tick_outside_move", 1, 0);
            if (quarter_active) begin
                if (!in_move) begin
                    in_move = 1; qa_len = 0; nticks = 0; first_off = -1;
                    last_tick = -1; spacing_bad = 0; dir0 = dir_out; dir_bad = 0;
                end
                if (step_tick) begin
                    if (last_tick >= 0 && (qa_len - last_tick) != P) spacing_bad++;
                    last_tick = qa_len;
                    nticks++;
                end
                if (step_count == 4'd1 && first_off < 0) first_off = qa_len;
                if (dir_out !== dir0) dir_bad = 1;
                qa_len++;
            end
            if (quarter_done) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_dir = exp_q.pop_front();
                    check("active_cycles", qa_len, S * P);
                    check("tick_count", nticks, S);
                    check("first_step_offset", first_off, P);
                    check("tick_spacing_errs", spacing_bad, 0);
                    check("final_step_count", step_count, S);
                    check("dir_out", dir0, exp_dir);
                    check("dir_stable", dir_bad, 0);
                    check("active_low_at_done", quarter_active, 0);
                end
                in_move = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!quarter_done && n < budget) begin
            cyc(1);
            n++;
        end
        if (!quarter_done) check("done_timeout", 0, 1);
        cyc(1);
    endtask

    task automatic wait_count(input int v, input int budget);
        int n = 0;
        while (step_count != v[3:0] && n < budget) begin
            cyc(1);
            n++;
        end
        if (step_count != v[3:0]) check("step_count_timeout", step_count, v);
    endtask

    task automatic hold_no_move(input string name, input int n);
        bit seen = 0;
        repeat (n) begin
            cyc(1);
            if (quarter_active) seen = 1;
        end
        check(name, seen, 0);
    endtask

    task automatic tap(input logic d, input int hold);
        dir_in = d;
        exp_q.push_back(d);
        key_n = 1'b0;
        cyc(hold);
        key_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; key_n = 1'b1; dir_in = 1'b0; on_switch = 1'b0;
        cyc(3);
        check("rst_quarter_active", quarter_active, 0);
        check("rst_step_tick", step_tick, 0);
        check("rst_quarter_done", quarter_done, 0);
        check("rst_step_count", step_count, 0);
        check("rst_dir_out", dir_out, 0);
        rst_n = 1'b1;
        cyc(30);

        // 1: clean press held 20 cycles
        tap(1'b0, 20);
        wait_done(100);
        cyc(20);

        // 2: bounces alone start nothing, then a solid press starts one move
        for (int i = 0; i < 6; i++) begin
            key_n = ~key_n;
            cyc(2);
        end
        hold_no_move("bounce_no_move", 4);
        tap(1'b1, 20);
        wait_done(100);
        cyc(20);

        // 3: key held long past the move -> no second move
        tap(1'b0, 1);
        key_n = 1'b0;
        wait_done(100);
        hold_no_move("hold_no_second_move", 100);
        key_n = 1'b1;
        cyc(20);
        tap(1'b0, 15);
        wait_done(100);
        cyc(20);

        // 4: on_switch blocks presses, but not a running move
        on_switch = 1'b1;
        key_n = 1'b0;
        hold_no_move("on_switch_blocks", 30);
        key_n = 1'b1;
        cyc(20);
        on_switch = 1'b0;
        tap(1'b1, 15);
        wait_count(3, 100);
        on_switch = 1'b1;
        wait_done(100);
        on_switch = 1'b0;
        cyc(20);

        // 5: dir_in changes mid-move are ignored
        tap(1'b1, 15);
        wait_count(4, 100);
        dir_in = 1'b0;
        wait_done(100);
        cyc(20);
        tap(1'b0, 15);
        wait_done(100);
        cyc(20);

        // 6: reset mid-move, key still held afterwards
        dir_in = 1'b0;
        key_n  = 1'b0;
        wait_count(5, 100);
        rst_n = 1'b0;
        cyc(1);
        check("midrst_quarter_active", quarter_active, 0);
        check("midrst_step_count", step_count, 0);
        check("midrst_quarter_done", quarter_done, 0);
        check("midrst_step_tick", step_tick, 0);
        rst_n = 1'b1;
        hold_no_move("held_through_reset", 40);
        key_n = 1'b1;
        cyc(30);
        tap(1'b0, 15);
        wait_done(100);
        cyc(10);

        check("queue_drained", exp_q.size(), 0);
        check("moves_completed", done_seen, 8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_quarter_turn_controller
`default_nettype wire
